// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter with per-requester lock and a watchdog for one shared UART byte transmitter.
module uart_tx_arbiter #(
   parameter logic [15:0] TIMEOUT = 16'd10000
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [3:0]  req,
   input  logic [3:0]  req_lock,
   input  logic [31:0] req_data,
   output logic [3:0]  ack,
   output logic        send_en,
   output logic [7:0]  tx_data,
   input  logic        tx_done,
   output logic [1:0]  owner,
   output logic        busy,
   output logic        timeout_err
);
   typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
   state_t      state;
   logic [15:0] wdog;
   logic        lock_hold;
   logic [1:0]  w;
   always_comb begin
      w = owner;
      for (int k = 4; k >= 1; k--) w = req[owner + 2'(k)] ? owner + 2'(k) : w;
      w = (lock_hold && req[owner]) ? owner : w;
   end
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state       <= IDLE;
         ack         <= '0;
         send_en     <= 1'b0;
         tx_data     <= '0;
         owner       <= 2'd3;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         lock_hold   <= 1'b0;
         wdog        <= '0;
      end else begin
         ack         <= '0;
         send_en     <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (lock_hold && !req[owner]) lock_hold <= 1'b0;
               if (|req) begin
                  tx_data <= req_data[{w, 3'b000} +: 8];
                  owner   <= w;
                  ack     <= 4'd1 << w;
                  send_en <= 1'b1;
                  busy    <= 1'b1;
                  state   <= SEND;
                  if (w != owner) lock_hold <= 1'b0;
               end
            end
            SEND: begin
               wdog  <= '0;
               state <= WAIT;
            end
            WAIT: begin
               wdog <= wdog + 16'd1;
               if (tx_done) begin
                  lock_hold <= req_lock[owner];
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else if (wdog + 16'd1 == TIMEOUT) begin
                  timeout_err <= 1'b1;
                  lock_hold   <= 1'b0;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed table-driven bench for uart_tx_arbiter plus timeout and reset sequences.
module tb_uart_tx_arbiter;
   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic [3:0]  req = '0;
   logic [3:0]  req_lock = '0;
   logic [31:0] req_data = '0;
   logic        tx_done = 1'b0;
   logic [3:0]  ack, ack_t;
   logic        send_en, send_en_t, busy, busy_t, timeout_err, timeout_err_t;
   logic [7:0]  tx_data, tx_data_t;
   logic [1:0]  owner, owner_t;
   int checks = 0;
   int errors = 0;
   typedef struct {
      bit          rst;
      logic [3:0]  req;
      logic [3:0]  lock;
      logic [31:0] rd;
      int          dly;
      logic [1:0]  w;
      logic [7:0]  d;
      int          gap;
   } vec_t;
   vec_t tv[11];
   always #5 Clk = ~Clk;
   uart_tx_arbiter dut (
      .Clk(Clk), .Reset_n(Reset_n), .req(req), .req_lock(req_lock), .req_data(req_data),
      .ack(ack), .send_en(send_en), .tx_data(tx_data), .tx_done(tx_done),
      .owner(owner), .busy(busy), .timeout_err(timeout_err)
   );
   uart_tx_arbiter #(.TIMEOUT(16'd16)) dut_t (
      .Clk(Clk), .Reset_n(Reset_n), .req(req), .req_lock(req_lock), .req_data(req_data),
      .ack(ack_t), .send_en(send_en_t), .tx_data(tx_data_t), .tx_done(tx_done),
      .owner(owner_t), .busy(busy_t), .timeout_err(timeout_err_t)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic do_reset();
      Reset_n = 1'b0;
      req = '0;
      req_lock = '0;
      tx_done = 1'b0;
      repeat (2) @(negedge Clk);
      chk("reset_state", {ack, send_en, tx_data, busy, timeout_err, owner}, {4'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd3});
      Reset_n = 1'b1;
   endtask
   task automatic wait_send(input bit t, output int n);
      n = 0;
      do begin
         @(negedge Clk);
         n++;
      end while (!(t ? send_en_t : send_en) && n < 50);
      if (!(t ? send_en_t : send_en)) n = -1;
   endtask
   initial begin
      int n;
      logic [3:0] exp_ack;
      tv = '{
         '{1'b1, 4'b0100, 4'b0000, 32'h00A5_0000, 100, 2'd2, 8'hA5, 1},
         '{1'b1, 4'b1111, 4'b0000, 32'h1312_1110,   5, 2'd0, 8'h10, 1},
         '{1'b0, 4'b1111, 4'b0000, 32'h1312_1110,   5, 2'd1, 8'h11, 1},
         '{1'b0, 4'b1111, 4'b0000, 32'h1312_1110,   5, 2'd2, 8'h12, 1},
         '{1'b0, 4'b1111, 4'b0000, 32'h1312_1110,   5, 2'd3, 8'h13, 1},
         '{1'b0, 4'b1111, 4'b0000, 32'h1312_1110,   5, 2'd0, 8'h10, 1},
         '{1'b1, 4'b0011, 4'b0010, 32'h1312_1110,   3, 2'd0, 8'h10, 1},
         '{1'b0, 4'b0011, 4'b0010, 32'h1312_1110,   3, 2'd1, 8'h11, 1},
         '{1'b0, 4'b0011, 4'b0010, 32'h1312_1110,   3, 2'd1, 8'h11, 1},
         '{1'b0, 4'b0011, 4'b0000, 32'h1312_1110,   3, 2'd1, 8'h11, 1},
         '{1'b0, 4'b0011, 4'b0000, 32'h1312_1110,   3, 2'd0, 8'h10, 1}
      };
      for (int i = 0; i < 11; i++) begin
         if (tv[i].rst) do_reset();
         req = tv[i].req;
         req_lock = tv[i].lock;
         req_data = tv[i].rd;
         wait_send(1'b0, n);
         chk($sformatf("v%0d_latency", i), n, tv[i].gap);
         exp_ack = 4'd1 << tv[i].w;
         chk($sformatf("v%0d_grant", i), {ack, owner, tx_data, busy}, {exp_ack, tv[i].w, tv[i].d, 1'b1});
         @(negedge Clk);
         chk($sformatf("v%0d_pulse", i), {ack, send_en, busy}, {4'b0, 1'b0, 1'b1});
         repeat (tv[i].dly - 1) @(negedge Clk);
         tx_done = 1'b1;
         @(negedge Clk);
         tx_done = 1'b0;
         chk($sformatf("v%0d_busy_drop", i), busy, 1'b0);
      end
      do_reset();
      req = 4'b1000;
      req_lock = 4'b1000;
      wait_send(1'b1, n);
      chk("to_first_grant", {n[7:0], owner_t, ack_t}, {8'd1, 2'd3, 4'b1000});
      repeat (3) @(negedge Clk);
      tx_done = 1'b1;
      @(negedge Clk);
      tx_done = 1'b0;
      wait_send(1'b1, n);
      chk("to_locked_grant", {n[7:0], owner_t, dut_t.lock_hold}, {8'd1, 2'd3, 1'b1});
      n = 0;
      do begin
         @(negedge Clk);
         n++;
      end while (!timeout_err_t && n < 100);
      chk("to_latency", n, 17);
      chk("to_state", {busy_t, dut_t.lock_hold}, {1'b0, 1'b0});
      @(negedge Clk);
      chk("to_regrant", {send_en_t, ack_t, owner_t, timeout_err_t}, {1'b1, 4'b1000, 2'd3, 1'b0});
      do_reset();
      tx_done = 1'b1;
      @(negedge Clk);
      tx_done = 1'b0;
      chk("spurious_done", {ack, send_en, tx_data, busy, timeout_err, owner}, {4'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd3});
      req = 4'b0100;
      req_data = 32'h00C3_0000;
      wait_send(1'b0, n);
      chk("mid_grant", {n[7:0], owner, tx_data}, {8'd1, 2'd2, 8'hC3});
      @(negedge Clk);
      req = '0;
      Reset_n = 1'b0;
      @(negedge Clk);
      chk("mid_reset", {ack, send_en, tx_data, busy, timeout_err, owner}, {4'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd3});
      Reset_n = 1'b1;
      req = 4'b1001;
      req_data = 32'h5500_0066;
      wait_send(1'b0, n);
      chk("post_reset_grant", {n[7:0], owner, ack, tx_data}, {8'd1, 2'd0, 4'b0001, 8'h66});
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
